// File: rtl/arcade_keymap.sv
// ---------------------------------------------------------------------------
// arcade_keymap
//
// Programmable PS/2-to-button mapper for arcade cores. A small keymap table
// maps {extended, scancode} pairs to button indices; several keys may drive
// one button. The merged result, ORed with the joystick bits, drives the
// core's active-low button bus.
//
// Every PS/2 event is applied by walking the whole table once, one entry per
// clock, while busy is high. One further event can wait in a single-entry
// pending slot during a walk. An event that arrives while that slot is
// occupied is lost and latches evt_drop until reset.
//
// Optional feature (macro AUTOFIRE_EN): a free-running half-period counter
// produces af_phase. Buttons selected by af_mask pulse at that rate while
// their keys are held. Without the macro, af_mask and AF_DIV are unused.
//
// Parameters:
//   NUM_BTN    number of button outputs (1..32)
//   MAP_DEPTH  keymap table entries (power of 2, 2..256)
//   AF_DIV     autofire half-period in clk_sys cycles
//
// Ports:
//   clk_sys   in   core clock, all logic on the rising edge
//   RESET_L   in   synchronous active-low reset
//   ps2_key   in   [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   joy_in    in   active-high joystick bits, one per button
//   map_wr    in   table write strobe (one entry per cycle)
//   map_addr  in   table entry index
//   map_data  in   [15] valid, [14] ext wildcard, [13:5] {ext,scan}, [4:0] button
//   af_mask   in   per-button autofire enable (AUTOFIRE_EN only)
//   btn_n     out  active-low merged buttons
//   busy      out  table walk in progress
//   evt_drop  out  sticky flag: a key event was lost
// ---------------------------------------------------------------------------
module arcade_keymap #(
  parameter int NUM_BTN   = 8,
  parameter int MAP_DEPTH = 32,
  parameter int AF_DIV    = 416667
) (
  input  logic                         clk_sys,
  input  logic                         RESET_L,
  input  logic [10:0]                  ps2_key,
  input  logic [NUM_BTN-1:0]           joy_in,
  input  logic                         map_wr,
  input  logic [$clog2(MAP_DEPTH)-1:0] map_addr,
  input  logic [15:0]                  map_data,
  input  logic [NUM_BTN-1:0]           af_mask,
  output logic [NUM_BTN-1:0]           btn_n,
  output logic                         busy,
  output logic                         evt_drop
);

  localparam int AW = $clog2(MAP_DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q;
  logic [AW-1:0]        idx_q;
  logic [9:0]           evt_q;
  logic                 busy_q;
  logic                 oldTog_q;
  logic                 pendValid_q;
  logic [9:0]           pend_q;
  logic                 evtDrop_q;
  logic [NUM_BTN-1:0]   btn_q;

  logic [MAP_DEPTH-1:0] entValid_q;
  logic [MAP_DEPTH-1:0] held_q;
  logic                 entWild_q [MAP_DEPTH];
  logic [8:0]           entCode_q [MAP_DEPTH];
  logic [4:0]           entBtn_q  [MAP_DEPTH];

  logic                 toggleEvt;
  logic                 loadEvt;
  logic                 entMatch;
  logic [NUM_BTN-1:0]   keyAct;
  logic [NUM_BTN-1:0]   keyGated;

  assign toggleEvt = ps2_key[10] != oldTog_q;
  assign loadEvt   = (state_q == IDLE) && pendValid_q;

  // Extended bit is ignored for wildcard entries.
  assign entMatch = entValid_q[idx_q]
                 && (entCode_q[idx_q][7:0] == evt_q[7:0])
                 && ((entCode_q[idx_q][8] == evt_q[8]) || entWild_q[idx_q]);

  // Payload fields of the table need no reset: valid gates everything.
  always_ff @(posedge clk_sys) begin
    if (map_wr) begin
      entWild_q[map_addr] <= map_data[14];
      entCode_q[map_addr] <= map_data[13:5];
      entBtn_q[map_addr]  <= map_data[4:0];
    end
  end

  // Button b is active while any valid, held entry points at it. Entries
  // whose index is NUM_BTN or above never match any b and so stay silent.
  always_comb begin
    keyAct = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (entValid_q[i] && held_q[i] && (entBtn_q[i] == 5'(b))) begin
          keyAct[b] = 1'b1;
        end
      end
    end
  end

`ifdef AUTOFIRE_EN
  logic [31:0] afCnt_q;
  logic        afPhase_q;

  always_ff @(posedge clk_sys) begin
    if (!RESET_L) begin
      afCnt_q   <= '0;
      afPhase_q <= 1'b0;
    end else if (afCnt_q == 32'(AF_DIV - 1)) begin
      afCnt_q   <= '0;
      afPhase_q <= ~afPhase_q;
    end else begin
      afCnt_q <= afCnt_q + 32'd1;
    end
  end

  assign keyGated = keyAct & ~(af_mask & {NUM_BTN{~afPhase_q}});
`else
  logic unusedAf;
  assign unusedAf = ^{af_mask, 32'(AF_DIV)};
  assign keyGated = keyAct;
`endif

  // Event capture, table walk, held bits and the output register. A table
  // write placed after the walk update lets the write win on a collision.
  always_ff @(posedge clk_sys) begin
    if (!RESET_L) begin
      oldTog_q    <= ps2_key[10];
      pendValid_q <= 1'b0;
      pend_q      <= '0;
      evtDrop_q   <= 1'b0;
      state_q     <= IDLE;
      idx_q       <= '0;
      evt_q       <= '0;
      busy_q      <= 1'b0;
      entValid_q  <= '0;
      held_q      <= '0;
      btn_q       <= '1;
    end else begin
      oldTog_q <= ps2_key[10];

      // The slot being emptied this cycle can accept a new event.
      if (toggleEvt) begin
        if (pendValid_q && !loadEvt) begin
          evtDrop_q <= 1'b1;
        end else begin
          pend_q      <= ps2_key[9:0];
          pendValid_q <= 1'b1;
        end
      end else if (loadEvt) begin
        pendValid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pendValid_q) begin
            evt_q   <= pend_q;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (entMatch) begin
            held_q[idx_q] <= evt_q[9];
          end
          if (idx_q == AW'(MAP_DEPTH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (map_wr) begin
        entValid_q[map_addr] <= map_data[15];
        held_q[map_addr]     <= 1'b0;
      end

      btn_q <= ~(keyGated | joy_in);
    end
  end

  assign btn_n    = btn_q;
  assign busy     = busy_q;
  assign evt_drop = evtDrop_q;

endmodule

// File: tb/tb_arcade_keymap.sv
// ---------------------------------------------------------------------------
// tb_arcade_keymap
//
// Self-checking bench for arcade_keymap. Expected button states come either
// from hand-written vector tables or from an event-level model: a list of
// table entries with a held flag each, where every key event simply sets or
// clears held on all matching entries.
// ---------------------------------------------------------------------------
module tb_arcade_keymap;

  localparam int NB  = 8;
  localparam int MD  = 32;
  localparam int AFD = 10;

  logic        clk_sys = 1'b0;
  logic        RESET_L = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [NB-1:0] joy_in = '0;
  logic        map_wr = 1'b0;
  logic [4:0]  map_addr = '0;
  logic [15:0] map_data = '0;
  logic [NB-1:0] af_mask = '0;
  logic [NB-1:0] btn_n;
  logic        busy;
  logic        evt_drop;

  always #5 clk_sys = ~clk_sys;

  arcade_keymap #(.NUM_BTN(NB), .MAP_DEPTH(MD), .AF_DIV(AFD)) dut (
    .clk_sys (clk_sys),
    .RESET_L (RESET_L),
    .ps2_key (ps2_key),
    .joy_in  (joy_in),
    .map_wr  (map_wr),
    .map_addr(map_addr),
    .map_data(map_data),
    .af_mask (af_mask),
    .btn_n   (btn_n),
    .busy    (busy),
    .evt_drop(evt_drop)
  );

  int   errors = 0;
  int   checks = 0;
  logic tog = 1'b0;

  // Event-level reference model of the keymap table.
  logic       mValid [MD];
  logic       mWild  [MD];
  logic [8:0] mCode  [MD];
  logic [4:0] mBtn   [MD];
  logic       mHeld  [MD];

  typedef struct {
    logic [8:0] code;
    logic       pressed;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [15];

  function automatic void modelReset();
    for (int i = 0; i < MD; i++) begin
      mValid[i] = 1'b0;
      mHeld[i]  = 1'b0;
      mWild[i]  = 1'b0;
      mCode[i]  = '0;
      mBtn[i]   = '0;
    end
  endfunction

  function automatic void modelWrite(input int addr, input logic [15:0] data);
    mValid[addr] = data[15];
    mWild[addr]  = data[14];
    mCode[addr]  = data[13:5];
    mBtn[addr]   = data[4:0];
    mHeld[addr]  = 1'b0;
  endfunction

  function automatic void modelEvent(input logic [8:0] code, input logic pressed);
    for (int i = 0; i < MD; i++) begin
      if (mValid[i] && mCode[i][7:0] == code[7:0] && (mWild[i] || mCode[i][8] == code[8])) begin
        mHeld[i] = pressed;
      end
    end
  endfunction

  function automatic logic [7:0] modelBtnN();
    logic [7:0] act;
    act = '0;
    for (int i = 0; i < MD; i++) begin
      if (mValid[i] && mHeld[i] && int'(mBtn[i]) < NB) begin
        act = act | (8'd1 << mBtn[i]);
      end
    end
    return ~(act | joy_in);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one PS/2 event at a falling edge (model is updated by caller).
  task automatic applyStimulus(input logic [8:0] code, input logic pressed);
    @(negedge clk_sys);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  // Waits the worst-case toggle-to-button latency, then lands on a falling edge.
  task automatic settle(input int scans);
    repeat (scans * (MD + 3)) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic writeEntry(input int addr, input logic [15:0] data);
    @(negedge clk_sys);
    map_wr   = 1'b1;
    map_addr = 5'(addr);
    map_data = data;
    @(negedge clk_sys);
    map_wr = 1'b0;
    modelWrite(addr, data);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk_sys);
    RESET_L = 1'b0;
    repeat (cycles) @(posedge clk_sys);
    @(negedge clk_sys);
    RESET_L = 1'b1;
    modelReset();
  endtask

  function automatic logic [15:0] entry(input logic v, input logic w, input logic [8:0] code, input logic [4:0] b);
    return {v, w, code, b};
  endfunction

  logic [8:0] codeSet [6];

  initial begin
    logic [7:0] expBtn;
    logic       sawBusy;

    codeSet[0] = 9'h01C; codeSet[1] = 9'h11C; codeSet[2] = 9'h074;
    codeSet[3] = 9'h174; codeSet[4] = 9'h03A; codeSet[5] = 9'h16B;

    vecs[0]  = '{9'h01C, 1'b1, 8'hFD, "A press"};
    vecs[1]  = '{9'h16B, 1'b1, 8'hFD, "ext 16B press"};
    vecs[2]  = '{9'h01C, 1'b0, 8'hFD, "A release, 16B still held"};
    vecs[3]  = '{9'h16B, 1'b0, 8'hFF, "16B release"};
    vecs[4]  = '{9'h174, 1'b1, 8'hFB, "174 hits wildcard only"};
    vecs[5]  = '{9'h074, 1'b1, 8'hF3, "074 hits both entries"};
    vecs[6]  = '{9'h174, 1'b0, 8'hF7, "174 release wildcard only"};
    vecs[7]  = '{9'h074, 1'b0, 8'hFF, "074 release"};
    vecs[8]  = '{9'h029, 1'b1, 8'hFF, "button index out of range"};
    vecs[9]  = '{9'h033, 1'b1, 8'hFF, "invalid entry"};
    vecs[10] = '{9'h11C, 1'b1, 8'hDF, "ext 11C press"};
    vecs[11] = '{9'h11C, 1'b1, 8'hDF, "typematic repeat"};
    vecs[12] = '{9'h01C, 1'b0, 8'hDF, "release of unheld entry"};
    vecs[13] = '{9'h11C, 1'b0, 8'hFF, "11C release"};
    vecs[14] = '{9'h029, 1'b0, 8'hFF, "out of range release"};

    // Reset state.
    modelReset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("reset btn_n", 32'(btn_n), 32'hFF);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset evt_drop", 32'(evt_drop), 32'h0);
    RESET_L = 1'b1;

    // Single key on button 4, including busy timing.
    writeEntry(0, entry(1'b1, 1'b0, 9'h03A, 5'd4));
    applyStimulus(9'h03A, 1'b1);
    modelEvent(9'h03A, 1'b1);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("busy during walk", 32'(busy), 32'h1);
    repeat (MD + 1) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("0x03A press btn_n", 32'(btn_n), 32'hEF);
    checkOutput("busy after walk", 32'(busy), 32'h0);
    applyStimulus(9'h03A, 1'b0);
    modelEvent(9'h03A, 1'b0);
    settle(1);
    checkOutput("0x03A release btn_n", 32'(btn_n), 32'hFF);

    // Fixed table, vectors applied from the table above.
    writeEntry(1, entry(1'b1, 1'b0, 9'h01C, 5'd1));
    writeEntry(2, entry(1'b1, 1'b0, 9'h16B, 5'd1));
    writeEntry(3, entry(1'b1, 1'b1, 9'h074, 5'd2));
    writeEntry(4, entry(1'b1, 1'b0, 9'h074, 5'd3));
    writeEntry(5, entry(1'b1, 1'b0, 9'h029, 5'd9));
    writeEntry(6, entry(1'b1, 1'b0, 9'h11C, 5'd5));
    writeEntry(7, entry(1'b0, 1'b0, 9'h033, 5'd6));
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].code, vecs[v].pressed);
      modelEvent(vecs[v].code, vecs[v].pressed);
      settle(1);
      checkOutput(vecs[v].name, 32'(btn_n), 32'(vecs[v].exp));
    end
    applyStimulus(9'h033, 1'b0);
    modelEvent(9'h033, 1'b0);
    settle(1);

    // Removing a held entry releases its button; rewriting does not re-press.
    applyStimulus(9'h03A, 1'b1);
    modelEvent(9'h03A, 1'b1);
    settle(1);
    checkOutput("held before removal", 32'(btn_n), 32'hEF);
    writeEntry(0, entry(1'b0, 1'b0, 9'h03A, 5'd4));
    @(negedge clk_sys);
    checkOutput("removal releases button", 32'(btn_n), 32'hFF);
    writeEntry(0, entry(1'b1, 1'b0, 9'h03A, 5'd4));
    @(negedge clk_sys);
    checkOutput("rewrite stays released", 32'(btn_n), 32'hFF);
    applyStimulus(9'h03A, 1'b0);
    modelEvent(9'h03A, 1'b0);
    settle(1);

    // Three toggles within five cycles: the third is dropped.
    applyStimulus(9'h01C, 1'b1);
    modelEvent(9'h01C, 1'b1);
    @(negedge clk_sys);
    applyStimulus(9'h174, 1'b1);
    modelEvent(9'h174, 1'b1);
    @(negedge clk_sys);
    applyStimulus(9'h03A, 1'b1);
    settle(2);
    checkOutput("drop: first two applied", 32'(btn_n), 32'hF9);
    checkOutput("drop: model agrees", 32'(btn_n), 32'(modelBtnN()));
    checkOutput("drop: evt_drop set", 32'(evt_drop), 32'h1);
    applyStimulus(9'h01C, 1'b0);
    modelEvent(9'h01C, 1'b0);
    settle(1);
    applyStimulus(9'h174, 1'b0);
    modelEvent(9'h174, 1'b0);
    settle(1);
    checkOutput("drop: all released", 32'(btn_n), 32'hFF);
    checkOutput("drop: evt_drop sticky", 32'(evt_drop), 32'h1);

    // Key held across a one-cycle reset.
    applyStimulus(9'h01C, 1'b1);
    modelEvent(9'h01C, 1'b1);
    settle(1);
    checkOutput("held before reset", 32'(btn_n), 32'hFD);
    doReset(1);
    checkOutput("after reset btn_n", 32'(btn_n), 32'hFF);
    checkOutput("after reset evt_drop", 32'(evt_drop), 32'h0);
    sawBusy = 1'b0;
    repeat (4) begin
      @(negedge clk_sys);
      sawBusy = sawBusy | busy;
    end
    checkOutput("no event on reset exit", 32'(sawBusy), 32'h0);
    joy_in = 8'h01;
    #1;
    checkOutput("joy registered, not yet", 32'(btn_n), 32'hFF);
    @(negedge clk_sys);
    checkOutput("joy one cycle latency", 32'(btn_n), 32'hFE);
    joy_in = 8'h00;
    @(negedge clk_sys);

    // Table write colliding with the walk of the same entry.
    writeEntry(10, entry(1'b1, 1'b0, 9'h01C, 5'd1));
    applyStimulus(9'h01C, 1'b1);
    modelEvent(9'h01C, 1'b1);
    repeat (12) @(posedge clk_sys);
    @(negedge clk_sys);
    map_wr   = 1'b1;
    map_addr = 5'd10;
    map_data = entry(1'b1, 1'b0, 9'h01C, 5'd1);
    @(negedge clk_sys);
    map_wr = 1'b0;
    modelWrite(10, entry(1'b1, 1'b0, 9'h01C, 5'd1));
    settle(1);
    checkOutput("write wins over match", 32'(btn_n), 32'hFF);

    // Random table and events against the model.
    doReset(2);
    for (int i = 0; i < MD; i++) begin
      writeEntry(i, entry(($urandom_range(3) != 0), 1'($urandom_range(1)),
                          codeSet[$urandom_range(5)], 5'($urandom_range(9))));
    end
    for (int n = 0; n < 40; n++) begin
      logic [8:0] c;
      logic       p;
      c = codeSet[$urandom_range(5)];
      p = 1'($urandom_range(1));
      applyStimulus(c, p);
      joy_in = 8'($urandom_range(255)) & 8'h81;
      modelEvent(c, p);
      settle(1);
      expBtn = modelBtnN();
      checkOutput($sformatf("random event %0d", n), 32'(btn_n), 32'(expBtn));
      if ((n % 5) == 4) begin
        writeEntry($urandom_range(MD - 1), entry(1'b1, 1'($urandom_range(1)),
                   codeSet[$urandom_range(5)], 5'($urandom_range(9))));
        @(negedge clk_sys);
        checkOutput($sformatf("random write %0d", n), 32'(btn_n), 32'(modelBtnN()));
      end
    end
    joy_in = '0;
    checkOutput("random evt_drop clear", 32'(evt_drop), 32'h0);

`ifdef AUTOFIRE_EN
    // Autofire: held key on button 4 pulses with a half-period of AF_DIV.
    begin
      int lastEdge;
      int edges;
      int badGap;
      logic prev;
      doReset(1);
      writeEntry(0, entry(1'b1, 1'b0, 9'h03A, 5'd4));
      af_mask = 8'h10;
      applyStimulus(9'h03A, 1'b1);
      modelEvent(9'h03A, 1'b1);
      settle(1);
      prev     = btn_n[4];
      lastEdge = -1;
      edges    = 0;
      badGap   = 0;
      for (int t = 0; t < 8 * AFD; t++) begin
        @(negedge clk_sys);
        if (btn_n[4] != prev) begin
          if (lastEdge >= 0 && (t - lastEdge) != AFD) badGap++;
          lastEdge = t;
          edges++;
        end
        prev = btn_n[4];
      end
      checkOutput("autofire gap", 32'(badGap), 32'h0);
      checkOutput("autofire toggles", 32'(edges >= 6), 32'h1);
      af_mask = '0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
